// File: rtl/ps2_calc_pkg.sv
// ps2_calc_pkg: scan codes, ASCII codes, receiver states and scan-code mapping
package ps2_calc_pkg;

    typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_MAIN_8 = 8'h3E;
    localparam logic [7:0] SC_KP_ADD = 8'h79;
    localparam logic [7:0] SC_KP_MUL = 8'h7C;
    localparam logic [7:0] SC_MINUS  = 8'h4E;
    localparam logic [7:0] SC_KP_SUB = 8'h7B;
    localparam logic [7:0] SC_SLASH  = 8'h4A;
    localparam logic [7:0] SC_EQUAL  = 8'h55;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_C      = 8'h21;

    localparam logic [0:9][7:0] SC_MAIN_DIGITS = {8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [0:9][7:0] SC_KP_DIGITS   = {8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                                  8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_C     = 8'h63;

    // Returns {hit, ascii}. After an E0 prefix only keypad '/' and Enter are
    // calculator keys; the other E0 codes are navigation keys and are dropped.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift, input logic ext);
        logic [8:0] r;
        r = '0;
        if (!ext) begin
            for (int i = 0; i < 10; i++) begin
                if (code == SC_MAIN_DIGITS[i] || code == SC_KP_DIGITS[i]) r = {1'b1, ASC_0 + 8'(i)};
            end
            if (code == SC_MAIN_8 && shift) r = {1'b1, ASC_STAR};
            if (code == SC_KP_ADD) r = {1'b1, ASC_PLUS};
            if (code == SC_KP_MUL) r = {1'b1, ASC_STAR};
            if (code == SC_MINUS || code == SC_KP_SUB) r = {1'b1, ASC_MINUS};
            if (code == SC_EQUAL) r = {1'b1, shift ? ASC_PLUS : ASC_EQ};
            if (code == SC_C) r = {1'b1, ASC_C};
        end
        if (code == SC_SLASH) r = {1'b1, ASC_SLASH};
        if (code == SC_ENTER) r = {1'b1, ASC_EQ};
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes the PS/2 lines and receives 11-bit frames with parity, stop and timeout checks
module ps2_frame_rx
    import ps2_calc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev, fall, bit_d;
    logic          stop_edge, timeout, good, bad;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shreg;
    logic          par;
    rx_state_t     state, nxt;

    assign fall  = clk_prev & ~clk_sync[1];
    assign bit_d = dat_sync[1];

    // Two-flop synchronizers plus delayed clock copy for falling-edge detection; idle bus is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RX_IDLE;
        else       state <= nxt;
    end

    // Next state: a low start bit enters RECV; the stop edge or a timeout returns to IDLE
    always_comb begin
        nxt = state;
        if (state == RX_IDLE && fall && !bit_d) nxt = RX_RECV;
        if (stop_edge || timeout) nxt = RX_IDLE;
    end

    // Frame outcome: good byte, or discard on high start bit, bad parity/stop, or timeout
    always_comb begin
        stop_edge = state == RX_RECV && fall && bit_cnt == 4'd10;
        timeout   = state == RX_RECV && !fall && to_cnt == TW'(TIMEOUT_CYC - 1);
        good      = stop_edge && bit_d && (^{shreg, par});
        bad       = (state == RX_IDLE && fall && bit_d) || (stop_edge && !good) || timeout;
    end

    // Bit counter, shift register, idle-cycle counter and registered result pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt    <= '0;
            to_cnt     <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= good;
            frame_err  <= bad;
            to_cnt     <= (state == RX_RECV && !fall && !timeout) ? to_cnt + 1'b1 : '0;
            if (good) rx_byte <= shreg;
            if (fall) begin
                bit_cnt <= (state == RX_IDLE) ? {3'b000, ~bit_d} : (stop_edge ? 4'd0 : bit_cnt + 4'd1);
                if (state == RX_RECV && bit_cnt < 4'd9) shreg <= {bit_d, shreg[7:1]};
                if (state == RX_RECV && bit_cnt == 4'd9) par <= bit_d;
            end
            if (timeout) bit_cnt <= '0;
        end
    end

endmodule

// File: rtl/ps2_ascii_frontend.sv
// ps2_ascii_frontend: PS/2 keyboard receiver plus scan-code to calculator ASCII decoder
module ps2_ascii_frontend
    import ps2_calc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    logic       ext_pending, brk_pending, shift_held;
    logic       is_shift;
    logic [8:0] hit;

    ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err)
    );

    // Classify the received byte and look up its ASCII mapping
    always_comb begin
        is_shift = rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT;
        hit      = map_code(rx_byte, shift_held, ext_pending);
    end

    // Decoder: prefix tracking, shift state, and one output pulse per mapped make code
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data        <= ASC_NUL;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            shift_held  <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= rx_err;
            if (rx_err) begin
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) ext_pending <= 1'b1;
                else if (rx_byte == SC_BRK) brk_pending <= 1'b1;
                else begin
                    ext_pending <= 1'b0;
                    if (brk_pending) begin
                        brk_pending <= 1'b0;
                        if (is_shift) shift_held <= 1'b0;
                    end else if (is_shift) shift_held <= 1'b1;
                    else if (hit[8]) begin
                        valid <= 1'b1;
                        data  <= hit[7:0];
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_ascii_frontend.md
PS2_ASCII_FRONTEND -- requirements
Module: ps2_ascii_frontend

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, the number of clk cycles without a ps2_clk falling edge after which a partial frame is aborted.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-003 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ps2_clk, input, 1, keyboard clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data, input, 1, keyboard data, asynchronous to clk.
REQ-006 SHALL have port data, output, 8, ASCII code of the last decoded key, held between pulses.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse marking a new data value; directly drives the calculator FSM data/valid inputs.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse on a discarded frame.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through two-flop synchronizers, and detect a ps2_clk falling edge from the synchronized value and its one-cycle-delayed copy.
REQ-010 SHALL run a receiver FSM with states IDLE and RECV; the first falling edge in IDLE samples the start bit and moves to RECV; bit counter 0..10.
REQ-011 SHALL assemble each frame as start(0), 8 data bits LSB first, odd parity, stop(1), sampling ps2_data on each falling edge.
REQ-012 SHALL discard the frame, pulse frame_err and return to IDLE on any of: start bit 1 (immediately), parity mismatch or stop bit 0 (at the stop edge).
REQ-013 SHALL treat TIMEOUT_CYC clk cycles without an edge while in RECV as a timeout: discard the frame, pulse frame_err, return to IDLE.
REQ-014 SHALL pass a good byte to the decoder in the cycle after the stop-bit edge is detected; valid SHALL rise in the following cycle (2 cycles after stop-edge detection).
REQ-015 SHALL, in the decoder, handle prefix byte 0xE0 by setting ext_pending and prefix byte 0xF0 by setting brk_pending; neither SHALL produce output.
REQ-016 SHALL consume the next code as a release when brk_pending is set: clear brk_pending and ext_pending; clear shift_held if the code is 0x12 or 0x59; produce no output.
REQ-017 SHALL make a code of 0x12 or 0x59 set shift_held, without output.
REQ-018 SHALL map main-row make codes 0x45,16,1E,26,25,2E,36,3D,3E,46 to '0'..'9' (0x30-0x39), except that shift_held with 0x3E gives '*' (0x2A).
REQ-019 SHALL map keypad codes 0x70,69,72,7A,6B,73,74,6C,75,7D to '0'..'9' independent of shift.
REQ-020 SHALL map: 0x79 to '+'; 0x7C to '*'; 0x4E and 0x7B to '-'; 0x4A (with or without E0) to '/'; 0x55 to '=', or to '+' when shift_held; 0x5A (with or without E0) to '='; 0x21 to 'c' (0x63).
REQ-021 SHALL drop unmapped make codes silently; every make code, including typematic repeats, SHALL clear ext_pending.
REQ-022 SHALL emit one valid pulse per mapped make code and update data in the same cycle; valid and frame_err SHALL never be high together.
REQ-023 SHALL clear ext_pending and brk_pending on frame_err; shift_held is retained.

Reset
REQ-024 SHALL, on rstn low, force data=0x00, valid=0, frame_err=0, receiver IDLE, bit counter/timeout counter 0, ext_pending=brk_pending=shift_held=0, synchronizers to 1 (bus idle).
REQ-025 SHALL abandon a partial frame on reset mid-frame, with no output pulse after release.

Structure
REQ-026 SHALL place scan-code constants, ASCII constants and the receiver state encoding in a shared package ps2_calc_pkg.
REQ-027 SHALL split out sub-module ps2_frame_rx (synchronizers, edge detect, receiver FSM, parity, timeout), emitting byte/byte_valid/frame_err; the scan-code decoder stays in the top.

Verification
REQ-028 SHALL cover: frames 0x2E then F0 2E -> exactly one valid with data=0x35; release produces nothing.
REQ-029 SHALL cover: 12, 55, F0 55, F0 12, 55 -> valid data=0x2B, then valid data=0x3D.
REQ-030 SHALL cover: E0 4A -> data=0x2F; E0 5A -> data=0x3D; 7C -> data=0x2A.
REQ-031 SHALL cover: 0x16 with wrong parity -> frame_err pulse, no valid; good 0x16 -> data=0x31.
REQ-032 SHALL cover: 5 bits then idle > TIMEOUT_CYC -> frame_err pulse; next frame 0x21 -> data=0x63.
REQ-033 SHALL cover: shift held, rstn pulsed mid-frame -> data=0x00, no pulse; then 0x55 -> data=0x3D.
